csa_accum_4to2: RTL

Multi-beat carry-save accumulator built on 4:2 compression. Each accepted beat carries four WIDTH-bit operands, which are folded into a redundant (sum, carry) accumulator pair without carry propagation. When the last beat of a packet is accepted, the pair is resolved by a single carry-propagate add and presented on a valid/ready result port. The block sits after partial-product generation in the multiplier datapath, and serves as the reusable multi-operand summation stage for wider or iterative multiplies.

---
 rtl/csa_accum_4to2.sv | 115 +++++++++++
 1 files changed

// File: rtl/csa_accum_4to2.sv
// Multi-beat carry-save accumulator: four operands per beat folded into a
// redundant sum/carry pair, resolved by one carry-propagate add per packet.
module csa_accum_4to2 #(
    parameter int WIDTH = 32,
    parameter int GUARD = 4,
    parameter int CNT_W = 8,
    localparam int ACC_W = WIDTH + GUARD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    input  logic [WIDTH-1:0] a3,
    input  logic [WIDTH-1:0] a4,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res,
    output logic [CNT_W-1:0] res_beats
);

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc_s;
    logic [ACC_W-1:0] acc_c;
    logic [CNT_W-1:0] beat_cnt;

    function automatic logic [ACC_W-1:0] csa_sum(
        input logic [ACC_W-1:0] x,
        input logic [ACC_W-1:0] y,
        input logic [ACC_W-1:0] z
    );
        return x ^ y ^ z;
    endfunction

    // Carry shifted up one place; the bit leaving the top is dropped (mod 2^ACC_W).
    function automatic logic [ACC_W-1:0] csa_cy(
        input logic [ACC_W-1:0] x,
        input logic [ACC_W-1:0] y,
        input logic [ACC_W-1:0] z
    );
        logic [ACC_W-1:0] maj;
        maj = (x & y) | (x & z) | (y & z);
        return {maj[ACC_W-2:0], 1'b0};
    endfunction

    logic [ACC_W-1:0] op1, op2, op3, op4;
    logic [ACC_W-1:0] s1, c1, s2, c2, s3, c3, s4, c4;

    assign op1 = {{GUARD{1'b0}}, a1};
    assign op2 = {{GUARD{1'b0}}, a2};
    assign op3 = {{GUARD{1'b0}}, a3};
    assign op4 = {{GUARD{1'b0}}, a4};

    // 6 -> 4 -> 3 -> 2 reduction tree
    assign s1 = csa_sum(acc_s, acc_c, op1);
    assign c1 = csa_cy(acc_s, acc_c, op1);
    assign s2 = csa_sum(op2, op3, op4);
    assign c2 = csa_cy(op2, op3, op4);
    assign s3 = csa_sum(s1, c1, s2);
    assign c3 = csa_cy(s1, c1, s2);
    assign s4 = csa_sum(s3, c3, c2);
    assign c4 = csa_cy(s3, c3, c2);

    assign in_ready = (state == ACCUM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            acc_s     <= '0;
            acc_c     <= '0;
            beat_cnt  <= '0;
            res       <= '0;
            res_beats <= '0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        acc_s <= s4;
                        acc_c <= c4;
                        if (beat_cnt != '1)
                            beat_cnt <= beat_cnt + 1'b1;
                        if (in_last)
                            state <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    res       <= acc_s + acc_c;
                    res_beats <= beat_cnt;
                    res_valid <= 1'b1;
                    acc_s     <= '0;
                    acc_c     <= '0;
                    beat_cnt  <= '0;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule
